// File: rtl/carrier_phase_pkg.sv
// Shared types and helpers for the carrier-phase recovery loop.
package carrier_phase_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACQ   = 2'b01,
    ST_TRACK = 2'b10
  } state_e;

  // Default loop gains, expressed as right-shift amounts.
  localparam int DEF_KP_ACQ = 4;
  localparam int DEF_KI_ACQ = 10;
  localparam int DEF_KP_TRK = 7;
  localparam int DEF_KI_TRK = 14;

  // Decision-directed phase error sgn(I)*Q - sgn(Q)*I, with sgn(0) = +1.
  // Operands arrive sign-extended to 32 bits; callers keep the low WIDTH+1 bits.
  function automatic logic signed [31:0] phase_err(input logic signed [31:0] i,
                                                   input logic signed [31:0] q);
    logic signed [31:0] a;
    logic signed [31:0] b;
    a = i[31] ? -q : q;
    b = q[31] ? -i : i;
    return a - b;
  endfunction

  // Signed add clamped to the range of a w-bit two's-complement word (w <= 62).
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi)      return hi;
    else if (s < lo) return lo;
    else             return s;
  endfunction

endpackage

// File: rtl/cpc_loop_filter.sv
// PI loop filter: saturating integrator plus a one-cycle proportional kick,
// with gains chosen by the acquire/track mode.
module cpc_loop_filter
  import carrier_phase_pkg::*;
#(
  parameter int PW     = 32,
  parameter int KP_ACQ = DEF_KP_ACQ,
  parameter int KI_ACQ = DEF_KI_ACQ,
  parameter int KP_TRK = DEF_KP_TRK,
  parameter int KI_TRK = DEF_KI_TRK
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 upd_i,
  input  logic                 freeze_i,
  input  logic                 trk_i,
  input  logic signed [PW-1:0] e_ph_i,
  output logic signed [PW-1:0] integ_o,
  output logic signed [PW-1:0] prop_o
);

  logic signed [PW-1:0] integ_q, integ_d, prop_q, prop_d, inc;
  logic signed [63:0]   sum;
  logic                 unused_sum_hi;

  assign inc = trk_i ? (e_ph_i >>> KI_TRK) : (e_ph_i >>> KI_ACQ);
  assign sum = sat_add({{(64-PW){integ_q[PW-1]}}, integ_q},
                       {{(64-PW){inc[PW-1]}}, inc}, PW);
  assign unused_sum_hi = ^sum[63:PW];

  // Integrate on each unfrozen update; a clear wins over the update.
  always_comb begin
    integ_d = integ_q;
    prop_d  = '0;
    if (upd_i && !freeze_i) begin
      integ_d = sum[PW-1:0];
      prop_d  = trk_i ? (e_ph_i >>> KP_TRK) : (e_ph_i >>> KP_ACQ);
    end
    if (clr_i) integ_d = '0;
  end

  // Filter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ_q <= '0;
      prop_q  <= '0;
    end else begin
      integ_q <= integ_d;
      prop_q  <= prop_d;
    end
  end

  assign integ_o = integ_q;
  assign prop_o  = prop_q;

endmodule

// File: rtl/carrier_phase_ctrl.sv
// Carrier-phase recovery controller: error stage, acquire/track FSM and NCO
// around a PI loop filter. Symbol strobe to phase correction is 3 clocks.
module carrier_phase_ctrl
  import carrier_phase_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int PHASE_WIDTH  = 32,
  parameter int KP_ACQ       = DEF_KP_ACQ,
  parameter int KI_ACQ       = DEF_KI_ACQ,
  parameter int KP_TRK       = DEF_KP_TRK,
  parameter int KI_TRK       = DEF_KI_TRK,
  parameter int LOCK_THRESH  = 2048,
  parameter int LOCK_COUNT   = 64,
  parameter int UNLOCK_COUNT = 16,
  parameter int ACQ_TIMEOUT  = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          freeze,
  input  logic signed [PHASE_WIDTH-1:0] freq_init,
  input  logic                          sym_valid_in,
  input  logic signed [WIDTH-1:0]       din_i,
  input  logic signed [WIDTH-1:0]       din_q,
  output logic [PHASE_WIDTH-1:0]        phase_out,
  output logic                          phase_valid,
  output logic                          locked,
  output logic                          acq_retry,
  output logic [1:0]                    state_out
);

  localparam int EW   = WIDTH + 1;
  localparam int SH   = PHASE_WIDTH - WIDTH - 1;
  localparam int CMAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(ACQ_TIMEOUT + 1);

  state_e                        state_q, state_d;
  logic signed [PHASE_WIDTH-1:0] freq_q, freq_d, phase_q, phase_d, e_ph, integ, prop;
  logic signed [EW-1:0]          err_q, err_w;
  logic signed [31:0]            err32;
  logic                          unused_err_hi;
  logic [EW:0]                   err_abs;
  logic                          take, upd_q, upd, in_lock, integ_clr, retry_q, retry_d;
  logic [CW-1:0]                 cnt_q, cnt_d;   // lock count in ACQ, unlock count in TRACK
  logic [TW-1:0]                 to_q, to_d;

  assign err32 = phase_err({{(32-WIDTH){din_i[WIDTH-1]}}, din_i},
                           {{(32-WIDTH){din_q[WIDTH-1]}}, din_q});
  assign err_w         = err32[EW-1:0];
  assign unused_err_hi = ^err32[31:EW];
  assign take          = sym_valid_in && enable && (state_q != ST_IDLE);

  // Error stage: register the phase error of each accepted symbol.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
      upd_q <= 1'b0;
    end else begin
      upd_q <= take;
      if (take) err_q <= err_w;
    end
  end

  assign e_ph    = {{(PHASE_WIDTH-EW){err_q[EW-1]}}, err_q} << SH;
  assign err_abs = err_q[EW-1] ? -{err_q[EW-1], err_q} : {err_q[EW-1], err_q};
  assign in_lock = err_abs < (EW+1)'(LOCK_THRESH);
  assign upd     = upd_q && !freeze;

  cpc_loop_filter #(
    .PW(PHASE_WIDTH), .KP_ACQ(KP_ACQ), .KI_ACQ(KI_ACQ), .KP_TRK(KP_TRK), .KI_TRK(KI_TRK)
  ) u_lf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (integ_clr),
    .upd_i   (upd_q && enable),
    .freeze_i(freeze),
    .trk_i   (state_q == ST_TRACK),
    .e_ph_i  (e_ph),
    .integ_o (integ),
    .prop_o  (prop)
  );

  // Acquire/track FSM with lock, unlock and timeout counters; enable low overrides all.
  always_comb begin
    state_d   = state_q;
    freq_d    = freq_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    retry_d   = 1'b0;
    integ_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        integ_clr = 1'b1;
        if (enable) begin
          state_d = ST_ACQ;
          freq_d  = freq_init;
          cnt_d   = '0;
          to_d    = '0;
        end
      end
      ST_ACQ: if (upd) begin
        cnt_d = in_lock ? cnt_q + CW'(1) : '0;
        to_d  = to_q + TW'(1);
        if (in_lock && cnt_q == CW'(LOCK_COUNT - 1)) begin
          state_d = ST_TRACK;
          cnt_d   = '0;
          to_d    = '0;
        end else if (to_q == TW'(ACQ_TIMEOUT - 1)) begin
          retry_d   = 1'b1;
          integ_clr = 1'b1;
          cnt_d     = '0;
          to_d      = '0;
        end
      end
      ST_TRACK: if (upd) begin
        cnt_d = in_lock ? '0 : cnt_q + CW'(1);
        if (!in_lock && cnt_q == CW'(UNLOCK_COUNT - 1)) begin
          state_d = ST_ACQ;
          cnt_d   = '0;
          to_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!enable) begin
      state_d   = ST_IDLE;
      freq_d    = '0;
      cnt_d     = '0;
      to_d      = '0;
      retry_d   = 1'b0;
      integ_clr = 1'b1;
    end
  end

  // NCO: free-running modulo-2^PHASE_WIDTH accumulator outside IDLE.
  always_comb begin
    phase_d = phase_q + freq_q + integ + prop;
    if (!enable || state_q == ST_IDLE) phase_d = '0;
  end

  // Control and NCO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      freq_q  <= '0;
      phase_q <= '0;
      cnt_q   <= '0;
      to_q    <= '0;
      retry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      retry_q <= retry_d;
    end
  end

  assign phase_out   = phase_q;
  assign phase_valid = (state_q != ST_IDLE);
  assign locked      = (state_q == ST_TRACK);
  assign acq_retry   = retry_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_carrier_phase_ctrl.sv
// Directed bench for carrier_phase_ctrl: hand-computed phase, state and pulse values.
module tb_carrier_phase_ctrl;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b0;
  logic               freeze = 1'b0;
  logic               sym_valid_in = 1'b0;
  logic signed [31:0] freq_init = '0;
  logic signed [15:0] din_i = '0;
  logic signed [15:0] din_q = '0;
  logic [31:0]        phase_out;
  logic               phase_valid, locked, acq_retry;
  logic [1:0]         state_out;
  logic [31:0]        p0;
  int                 n_tests = 0;
  int                 n_fail = 0;

  always #5 clk = ~clk;

  carrier_phase_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .freeze(freeze), .freq_init(freq_init),
    .sym_valid_in(sym_valid_in), .din_i(din_i), .din_q(din_q), .phase_out(phase_out),
    .phase_valid(phase_valid), .locked(locked), .acq_retry(acq_retry), .state_out(state_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    repeat (n) tick();
  endtask

  // One symbol strobe, captured on the next edge.
  task automatic sym(input logic [15:0] i, input logic [15:0] q);
    din_i = i; din_q = q; sym_valid_in = 1'b1;
    tick();
    sym_valid_in = 1'b0;
  endtask

  // Pass through IDLE and re-enter ACQ with a new frequency word.
  task automatic restart(input logic [31:0] f);
    enable = 1'b0;
    tick();
    freq_init = f; enable = 1'b1;
    tick();
  endtask

  initial begin
    // Reset values
    tickn(2);
    chk("rst_phase", phase_out, 32'h0);
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_valid", 32'(phase_valid), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_retry", 32'(acq_retry), 32'd0);
    rst_n = 1'b1;

    // Disabled: symbols ignored
    repeat (20) begin
      sym_valid_in = 1'($urandom_range(0, 1));
      din_i = 16'($urandom); din_q = 16'($urandom);
      tick();
    end
    sym_valid_in = 1'b0;
    chk("dis_phase", phase_out, 32'h0);
    chk("dis_state", 32'(state_out), 32'd0);
    chk("dis_valid", 32'(phase_valid), 32'd0);

    // Free-running NCO and wrap
    freq_init = 32'h0100_0000; enable = 1'b1;
    tick();
    chk("acq_state", 32'(state_out), 32'd1);
    chk("acq_valid", 32'(phase_valid), 32'd1);
    chk("nco_start", phase_out, 32'h0);
    tick();
    chk("nco_step", phase_out, 32'h0100_0000);
    tickn(254);
    chk("nco_top", phase_out, 32'hFF00_0000);
    tick();
    chk("nco_wrap", phase_out, 32'h0);
    tick();
    chk("nco_after_wrap", phase_out, 32'h0100_0000);

    // err = 0x1000-0x2000 = -4096 -> prop -2^23, integ -2^17 (ACQ gains)
    restart(32'h0);
    sym(16'h2000, 16'h1000);
    tick();
    chk("lat_c2", phase_out, 32'h0);
    tick();
    chk("lat_c3", phase_out, 32'hFF7E_0000);
    tick();
    chk("integ_only", phase_out, 32'hFF7C_0000);

    // Freeze: integ held, no proportional kick
    freeze = 1'b1;
    sym(16'h2000, 16'h1000);
    tickn(2);
    chk("freeze_a", phase_out, 32'hFF76_0000);
    tick();
    chk("freeze_b", phase_out, 32'hFF74_0000);
    freeze = 1'b0;

    // Negative I: err = -0x1000 + 0x2000 = +4096
    restart(32'h0);
    sym(16'hE000, 16'h1000);
    tickn(2);
    chk("neg_i", phase_out, 32'h0082_0000);

    // I = 0 counts as positive: err = +0x1000
    restart(32'h0);
    sym(16'h0000, 16'h1000);
    tickn(2);
    chk("sgn_zero", phase_out, 32'h0082_0000);

    // 64 zero-error symbols back to back: TRACK on the 64th update
    restart(32'h0);
    din_i = 16'h2000; din_q = 16'h2000; sym_valid_in = 1'b1;
    tickn(64);
    sym_valid_in = 1'b0;
    chk("lock63_state", 32'(state_out), 32'd1);
    chk("lock63_locked", 32'(locked), 32'd0);
    tick();
    chk("lock64_state", 32'(state_out), 32'd2);
    chk("lock64_locked", 32'(locked), 32'd1);
    chk("lock_phase", phase_out, 32'h0);

    // TRACK gains: err +4096 -> prop 2^20, integ 2^13
    sym(16'h1000, 16'h2000);
    tickn(2);
    chk("trk_gain", phase_out, 32'h0010_2000);
    tick();
    chk("trk_integ", phase_out, 32'h0010_4000);

    // 16 large-error symbols: back to ACQ on the 16th
    sym(16'h2000, 16'h2000);
    din_i = 16'h7FFF; din_q = 16'h0000; sym_valid_in = 1'b1;
    tickn(16);
    sym_valid_in = 1'b0;
    chk("unlock15_state", 32'(state_out), 32'd2);
    tick();
    chk("unlock16_state", 32'(state_out), 32'd1);
    chk("unlock16_locked", 32'(locked), 32'd0);

    // Drop enable: IDLE next clock
    enable = 1'b0;
    tick();
    chk("drop_state", 32'(state_out), 32'd0);
    chk("drop_phase", phase_out, 32'h0);
    chk("drop_valid", 32'(phase_valid), 32'd0);

    // Asynchronous reset mid-cycle
    restart(32'h0100_0000);
    tickn(3);
    chk("pre_arst", phase_out, 32'h0300_0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_phase", phase_out, 32'h0);
    chk("arst_state", 32'(state_out), 32'd0);
    chk("arst_valid", 32'(phase_valid), 32'd0);
    tick();
    rst_n = 1'b1;

    // Timeout: saturated integ, retry pulse on the 4096th symbol, integ cleared
    restart(32'h0);
    din_i = 16'h7FFF; din_q = 16'h0000; sym_valid_in = 1'b1;
    tickn(3000);
    p0 = phase_out;
    tick();
    chk("sat_step", phase_out - p0, 32'h7C00_0800);
    tickn(1095);
    sym_valid_in = 1'b0;
    chk("retry_before", 32'(acq_retry), 32'd0);
    tick();
    chk("retry_pulse", 32'(acq_retry), 32'd1);
    chk("retry_state", 32'(state_out), 32'd1);
    tick();
    chk("retry_end", 32'(acq_retry), 32'd0);
    p0 = phase_out;
    tick();
    chk("retry_integ0", phase_out - p0, 32'h0);

    // Lock and timeout reached on the same symbol: lock wins
    sym_valid_in = 1'b1;
    tickn(4032);
    din_i = 16'h2000; din_q = 16'h2000;
    tickn(64);
    sym_valid_in = 1'b0;
    chk("prio_before", 32'(state_out), 32'd1);
    tick();
    chk("prio_state", 32'(state_out), 32'd2);
    chk("prio_retry", 32'(acq_retry), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
